// File: rtl/uart_ram_wr_if.sv
// Handshake bundle between the hpdcache write port, the shared UART byte
// streams and the uart_ram_wr bridge (slave = bridge, master = environment).
interface uart_ram_wr_if;
  // write request: addr/len/id (size is not carried, beats are always 4 bytes)
  logic        mem_req_write_valid;
  logic        mem_req_write_ready;
  logic [31:0] mem_req_write_addr;
  logic [7:0]  mem_req_write_len;
  logic [3:0]  mem_req_write_id;
  // write data beats
  logic        mem_req_write_data_valid;
  logic        mem_req_write_data_ready;
  logic [31:0] mem_req_write_data;
  logic [3:0]  mem_req_write_be;
  logic        mem_req_write_last;
  // write response
  logic        mem_resp_w_valid;
  logic        mem_resp_w_ready;
  logic [1:0]  mem_resp_w_error;
  logic [3:0]  mem_resp_w_id;
  logic        mem_resp_w_is_atomic;
  // UART arbitration and byte streams
  logic        uart_req;
  logic        uart_gnt;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;

  modport slave (
    input  mem_req_write_valid, mem_req_write_addr, mem_req_write_len, mem_req_write_id,
    output mem_req_write_ready,
    input  mem_req_write_data_valid, mem_req_write_data, mem_req_write_be, mem_req_write_last,
    output mem_req_write_data_ready,
    output mem_resp_w_valid, mem_resp_w_error, mem_resp_w_id, mem_resp_w_is_atomic,
    input  mem_resp_w_ready,
    output uart_req,
    input  uart_gnt,
    output s_axis_tdata, s_axis_tvalid,
    input  s_axis_tready,
    input  m_axis_tdata, m_axis_tvalid,
    output m_axis_tready
  );

  modport master (
    output mem_req_write_valid, mem_req_write_addr, mem_req_write_len, mem_req_write_id,
    input  mem_req_write_ready,
    output mem_req_write_data_valid, mem_req_write_data, mem_req_write_be, mem_req_write_last,
    input  mem_req_write_data_ready,
    input  mem_resp_w_valid, mem_resp_w_error, mem_resp_w_id, mem_resp_w_is_atomic,
    output mem_resp_w_ready,
    input  uart_req,
    output uart_gnt,
    input  s_axis_tdata, s_axis_tvalid,
    output s_axis_tready,
    output m_axis_tdata, m_axis_tvalid,
    input  m_axis_tready
  );
endinterface

// File: rtl/uart_ram_wr.sv
// Serializes hpdcache write requests into the host byte protocol on the shared
// UART tx stream, waits for the host ack byte and returns one write response.
module uart_ram_wr #(
  parameter logic [31:0] AckTimeout = 32'd12000000,
  parameter logic [7:0]  AckByte    = 8'hC8,
  parameter logic [7:0]  CmdByte    = 8'h77
) (
  input  logic            clk_i,
  input  logic            reset_ni,
  uart_ram_wr_if.slave    bus
);

  localparam logic [1:0] RespOk  = 2'b00;
  localparam logic [1:0] RespNok = 2'b10;

  typedef enum logic [3:0] {
    Idle, Arb, SendCmd, SendLen, SendAddr, WaitBeat, SendBe, SendData, WaitAck, Resp
  } state_e;

  state_e      state_q;
  logic [31:0] addr_q;
  logic [7:0]  len_q;
  logic [3:0]  id_q;
  logic [7:0]  beat_cnt_q;
  logic [1:0]  byte_cnt_q;
  logic [31:0] data_q;
  logic [3:0]  be_q;
  logic        last_q;
  logic        err_q;
  logic [31:0] timer_q;

  logic        write_ready_q;
  logic        data_ready_q;
  logic        resp_valid_q;
  logic [1:0]  resp_error_q;
  logic [3:0]  resp_id_q;
  logic        uart_req_q;
  logic [7:0]  tdata_q;
  logic        tvalid_q;
  logic        rx_ready_q;

  assign bus.mem_req_write_ready      = write_ready_q;
  assign bus.mem_req_write_data_ready = data_ready_q;
  assign bus.mem_resp_w_valid         = resp_valid_q;
  assign bus.mem_resp_w_error         = resp_error_q;
  assign bus.mem_resp_w_id            = resp_id_q;
  assign bus.mem_resp_w_is_atomic     = 1'b0;
  assign bus.uart_req                 = uart_req_q;
  assign bus.s_axis_tdata             = tdata_q;
  assign bus.s_axis_tvalid            = tvalid_q;
  assign bus.m_axis_tready            = rx_ready_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q       <= Idle;
      addr_q        <= '0;
      len_q         <= '0;
      id_q          <= '0;
      beat_cnt_q    <= '0;
      byte_cnt_q    <= '0;
      data_q        <= '0;
      be_q          <= '0;
      last_q        <= 1'b0;
      err_q         <= 1'b0;
      timer_q       <= '0;
      write_ready_q <= 1'b0;
      data_ready_q  <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_error_q  <= '0;
      resp_id_q     <= '0;
      uart_req_q    <= 1'b0;
      tdata_q       <= '0;
      tvalid_q      <= 1'b0;
      rx_ready_q    <= 1'b0;
    end else begin
      case (state_q)
        Idle: begin
          write_ready_q <= 1'b1;
          if (bus.mem_req_write_valid && write_ready_q) begin
            write_ready_q <= 1'b0;
            addr_q        <= bus.mem_req_write_addr;
            len_q         <= bus.mem_req_write_len;
            id_q          <= bus.mem_req_write_id;
            beat_cnt_q    <= '0;
            err_q         <= 1'b0;
            uart_req_q    <= 1'b1;
            state_q       <= Arb;
          end
        end
        Arb: begin
          if (bus.uart_gnt) begin
            tvalid_q <= 1'b1;
            tdata_q  <= CmdByte;
            state_q  <= SendCmd;
          end
        end
        SendCmd: begin
          if (bus.s_axis_tready) begin
            tdata_q <= len_q;
            state_q <= SendLen;
          end
        end
        SendLen: begin
          if (bus.s_axis_tready) begin
            tdata_q    <= addr_q[7:0];
            byte_cnt_q <= '0;
            state_q    <= SendAddr;
          end
        end
        SendAddr: begin
          if (bus.s_axis_tready) begin
            if (byte_cnt_q == 2'd3) begin
              tvalid_q     <= 1'b0;
              data_ready_q <= 1'b1;
              state_q      <= WaitBeat;
            end else begin
              byte_cnt_q <= byte_cnt_q + 2'd1;
              tdata_q    <= addr_q[{byte_cnt_q + 2'd1, 3'b000} +: 8];
            end
          end
        end
        WaitBeat: begin
          if (bus.mem_req_write_data_valid) begin
            data_ready_q <= 1'b0;
            data_q       <= bus.mem_req_write_data;
            be_q         <= bus.mem_req_write_be;
            last_q       <= bus.mem_req_write_last;
            tvalid_q     <= 1'b1;
            tdata_q      <= {4'h0, bus.mem_req_write_be};
            state_q      <= SendBe;
          end
        end
        SendBe: begin
          if (bus.s_axis_tready) begin
            tdata_q    <= data_q[7:0];
            byte_cnt_q <= '0;
            state_q    <= SendData;
          end
        end
        SendData: begin
          if (bus.s_axis_tready) begin
            if (byte_cnt_q == 2'd3) begin
              tvalid_q   <= 1'b0;
              beat_cnt_q <= beat_cnt_q + 8'd1;
              // Compare the pre-increment index so len=255 never needs a 9th bit.
              if ((beat_cnt_q == len_q) || last_q) begin
                err_q      <= err_q | ((beat_cnt_q == len_q) != last_q);
                rx_ready_q <= 1'b1;
                timer_q    <= '0;
                state_q    <= WaitAck;
              end else begin
                data_ready_q <= 1'b1;
                state_q      <= WaitBeat;
              end
            end else begin
              byte_cnt_q <= byte_cnt_q + 2'd1;
              tdata_q    <= data_q[{byte_cnt_q + 2'd1, 3'b000} +: 8];
            end
          end
        end
        WaitAck: begin
          timer_q <= timer_q + 32'd1;
          // An rx byte takes priority over a timeout expiring in the same cycle.
          if (bus.m_axis_tvalid) begin
            rx_ready_q   <= 1'b0;
            uart_req_q   <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_id_q    <= id_q;
            resp_error_q <= (err_q || (bus.m_axis_tdata != AckByte)) ? RespNok : RespOk;
            state_q      <= Resp;
          end else if ((AckTimeout != 32'd0) && (timer_q == AckTimeout - 32'd1)) begin
            rx_ready_q   <= 1'b0;
            uart_req_q   <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_id_q    <= id_q;
            resp_error_q <= RespNok;
            state_q      <= Resp;
          end
        end
        Resp: begin
          if (bus.mem_resp_w_ready) begin
            resp_valid_q  <= 1'b0;
            resp_error_q  <= '0;
            resp_id_q     <= '0;
            write_ready_q <= 1'b1;
            state_q       <= Idle;
          end
        end
        default: state_q <= Idle;
      endcase
    end
  end

endmodule
